// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver:
//   - parity-mode encodings as seen on the parity_mode input
//   - receiver FSM state encoding
//   - minimum clocks per bit (smaller requests are clamped up to this)
//   - 3-input majority helper used by the bit sampler
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int MIN_CPD = 8;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_DELIVER   = 3'd6,
    ST_WAIT_HIGH = 3'd7
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
// Valid/ready delivery channel between the UART receiver and its consumer.
//   rx_data      received word, held while rx_valid
//   rx_valid     word available
//   rx_ready     consumer accepts when rx_valid & rx_ready
//   parity_err   qualifies the held word (meaningful only while rx_valid)
//   framing_err  qualifies the held word (meaningful only while rx_valid)
//   overrun_err  one-cycle pulse: a completed frame was dropped
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, framing_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, framing_err, overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_bit_sampler
// Front end of the UART receiver: 2-flop synchroniser, per-bit timer and
// 3-sample majority vote.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   rx_line       raw asynchronous serial input (idle high)
//   cpd           clocks per bit (already clamped and frozen by the caller)
//   run           timer enable; while low the timer is parked at 0
//   s             synchronised line value
//   fall_edge     s was 1 last cycle and is 0 now
//   sample_done   t == h+1 (third sample; bit_val valid this cycle)
//   bit_val       majority of samples at t = h-1, h, h+1
//   bit_end       t == cpd-1 (last clock of the current bit)
// -----------------------------------------------------------------------------
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CPD_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_line,
  input  logic [CPD_WIDTH-1:0] cpd,
  input  logic                 run,
  output logic                 s,
  output logic                 fall_edge,
  output logic                 sample_done,
  output logic                 bit_val,
  output logic                 bit_end
);

  logic                 sync1_reg, sync2_reg, prev_reg;
  logic                 samp0_reg, samp1_reg;
  logic [CPD_WIDTH-1:0] t_reg, t_next;
  logic [CPD_WIDTH-1:0] h;

  assign h = cpd >> 1;

  // Synchroniser and history flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      samp0_reg <= 1'b1;
      samp1_reg <= 1'b1;
      t_reg     <= '0;
    end else begin
      sync1_reg <= rx_line;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      t_reg     <= t_next;
      if (run && (t_reg == h - 1'b1)) samp0_reg <= sync2_reg;
      if (run && (t_reg == h))        samp1_reg <= sync2_reg;
    end
  end

  assign s           = sync2_reg;
  assign fall_edge   = prev_reg & ~sync2_reg;
  assign bit_end     = run && (t_reg == cpd - 1'b1);
  assign sample_done = run && (t_reg == h + 1'b1);
  // The third sample is the live synchronised value, so the vote is ready at t == h+1.
  assign bit_val     = maj3(samp0_reg, samp1_reg, sync2_reg);

  always_comb begin
    t_next = '0;
    if (run && !bit_end) t_next = t_reg + 1'b1;
  end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with runtime parity / stop-bit selection and a
// valid/ready output channel.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   cycles_per_databit   clocks per bit, values below MIN_CPD act as MIN_CPD
//   parity_mode          00 none, 01 even, 10 odd, 11 none
//   two_stop             1 = two stop bits expected
//   rx_line              asynchronous serial input, idle high
//   busy                 high whenever the FSM is not in IDLE
//   rx_if (master)       rx_data / rx_valid / rx_ready / parity_err /
//                        framing_err / overrun_err
// Configuration is frozen at start-bit detection for the whole frame.
// -----------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CPD_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CPD_WIDTH-1:0] cycles_per_databit,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_line,
  output logic                 busy,
  uart_rx_param_if.master      rx_if
);

  localparam int IDX_W = $clog2(DATA_BITS);

  state_t               state_reg, state_next;
  logic                 s, fall_edge, sample_done, bit_val, bit_end;
  logic                 run, start_frame, deliver;
  logic [CPD_WIDTH-1:0] cpd_reg, cpd_clamped;
  logic                 par_en_reg, par_odd_reg, two_stop_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] rx_shift_reg, shift_we;
  logic                 perr_reg, ferr_reg, par_mismatch, last_data_bit;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, parity_err_reg, framing_err_reg, overrun_reg;
  logic                 accept;

  assign cpd_clamped = (cycles_per_databit < CPD_WIDTH'(MIN_CPD)) ?
                       CPD_WIDTH'(MIN_CPD) : cycles_per_databit;

  uart_bit_sampler #(.CPD_WIDTH(CPD_WIDTH)) u_sampler (
    .clk         (clk),
    .resetn      (resetn),
    .rx_line     (rx_line),
    .cpd         (cpd_reg),
    .run         (run),
    .s           (s),
    .fall_edge   (fall_edge),
    .sample_done (sample_done),
    .bit_val     (bit_val),
    .bit_end     (bit_end)
  );

  assign last_data_bit = (bit_idx_reg == IDX_W'(DATA_BITS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:      if (fall_edge) state_next = ST_START;
      // A start bit that votes high at mid-bit is a glitch: drop it silently.
      ST_START:     if (sample_done && bit_val) state_next = ST_IDLE;
                    else if (bit_end)           state_next = ST_DATA;
      ST_DATA:      if (bit_end && last_data_bit)
                      state_next = par_en_reg ? ST_PARITY : ST_STOP1;
      ST_PARITY:    if (bit_end) state_next = ST_STOP1;
      // With one stop bit we hand off at mid-bit so a back-to-back start
      // edge in the second half of the stop bit is not missed.
      ST_STOP1:     if (!two_stop_reg && sample_done) state_next = ST_DELIVER;
                    else if (two_stop_reg && bit_end) state_next = ST_STOP2;
      ST_STOP2:     if (sample_done) state_next = ST_DELIVER;
      ST_DELIVER:   state_next = ferr_reg ? ST_WAIT_HIGH : ST_IDLE;
      // A break keeps the line low; wait for it to recover before re-arming.
      ST_WAIT_HIGH: if (s) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run         = 1'b0;
    busy        = 1'b1;
    start_frame = 1'b0;
    deliver     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy        = 1'b0;
        start_frame = fall_edge;
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: run = 1'b1;
      ST_DELIVER:   deliver = 1'b1;
      ST_WAIT_HIGH: ;
      default:      ;
    endcase
  end

  // ---------------- frame datapath ----------------
  // Even mode expects XOR(data, parity) == 0, odd mode expects 1.
  assign par_mismatch = ((^rx_shift_reg) ^ bit_val) != par_odd_reg;

  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift_we
    assign shift_we[gi] = (state_reg == ST_DATA) && sample_done &&
                          (bit_idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpd_reg      <= CPD_WIDTH'(MIN_CPD);
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      bit_idx_reg  <= '0;
      rx_shift_reg <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      if (start_frame) begin
        cpd_reg      <= cpd_clamped;
        par_en_reg   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_odd_reg  <= (parity_mode == PAR_ODD);
        two_stop_reg <= two_stop;
        bit_idx_reg  <= '0;
        perr_reg     <= 1'b0;
        ferr_reg     <= 1'b0;
      end
      rx_shift_reg <= (rx_shift_reg & ~shift_we) | ({DATA_BITS{bit_val}} & shift_we);
      if ((state_reg == ST_DATA) && bit_end)
        bit_idx_reg <= bit_idx_reg + 1'b1;
      if ((state_reg == ST_PARITY) && sample_done && par_mismatch)
        perr_reg <= 1'b1;
      if (((state_reg == ST_STOP1) || (state_reg == ST_STOP2)) && sample_done && !bit_val)
        ferr_reg <= 1'b1;
    end
  end

  // ---------------- output handshake register ----------------
  assign accept = rx_valid_reg & rx_if.rx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      parity_err_reg  <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (deliver) begin
        // Accept and reload in the same cycle is a normal hand-over, not an overrun.
        if (!rx_valid_reg || accept) begin
          rx_data_reg     <= rx_shift_reg;
          parity_err_reg  <= perr_reg;
          framing_err_reg <= ferr_reg;
          rx_valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (accept) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data     = rx_data_reg;
  assign rx_if.rx_valid    = rx_valid_reg;
  assign rx_if.parity_err  = parity_err_reg;
  assign rx_if.framing_err = framing_err_reg;
  assign rx_if.overrun_err = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Self-checking bench for uart_rx_param: an 8-bit and a 5-bit instance.
// Frames are built from a bit-level description; expected word, parity and
// framing results come from a small frame-level model.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [9:0] cpd8, cpd5;
  logic [1:0] pm8, pm5;
  logic       ts8, ts5, line8, line5, busy8, busy5;

  uart_rx_param_if #(.DATA_BITS(8)) if8 ();
  uart_rx_param_if #(.DATA_BITS(5)) if5 ();

  uart_rx_param #(.DATA_BITS(8), .CPD_WIDTH(10)) dut8 (
    .clk(clk), .resetn(resetn), .cycles_per_databit(cpd8), .parity_mode(pm8),
    .two_stop(ts8), .rx_line(line8), .busy(busy8), .rx_if(if8.master)
  );

  uart_rx_param #(.DATA_BITS(5), .CPD_WIDTH(10)) dut5 (
    .clk(clk), .resetn(resetn), .cycles_per_databit(cpd5), .parity_mode(pm5),
    .two_stop(ts5), .rx_line(line5), .busy(busy5), .rx_if(if5.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [10:0] q8[$];
  logic [10:0] q5[$];
  int vcnt8 = 0, acc8 = 0, ovr8 = 0, ovr5 = 0;

  always @(negedge clk) begin
    if (if8.rx_valid) vcnt8++;
    if (if8.rx_valid && if8.rx_ready) begin
      acc8++;
      q8.push_back({if8.framing_err, if8.parity_err, 1'b0, if8.rx_data});
    end
    if (if8.overrun_err) ovr8++;
    if (if5.rx_valid && if5.rx_ready)
      q5.push_back({if5.framing_err, if5.parity_err, 4'b0, if5.rx_data});
    if (if5.overrun_err) ovr5++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel5, input logic v);
    if (sel5) line5 = v;
    else      line8 = v;
  endtask

  // Holds one bit for cpd clocks; optional one-clock inverted spike near mid-bit.
  task automatic send_bit(input bit sel5, input logic v, input int cpd, input bit spike);
    for (int c = 0; c < cpd; c++) begin
      set_line(sel5, (spike && c == cpd / 2 + 1) ? ~v : v);
      tick(1);
    end
  endtask

  task automatic send_frame(input bit sel5, input logic [8:0] data, input int nbits,
                            input int cpd, input bit has_par, input logic pbit,
                            input logic st1, input bit two, input logic st2,
                            input int spike_idx);
    send_bit(sel5, 1'b0, cpd, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel5, data[i], cpd, i == spike_idx);
    if (has_par) send_bit(sel5, pbit, cpd, 1'b0);
    send_bit(sel5, st1, cpd, 1'b0);
    if (two) send_bit(sel5, st2, cpd, 1'b0);
    set_line(sel5, 1'b1);
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic logic model_perr(input logic [8:0] d, input int nbits,
                                      input logic [1:0] pm, input logic pbit);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    ones += int'(pbit);
    if (pm == PAR_EVEN) return (ones % 2) != 0;
    if (pm == PAR_ODD)  return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic model_ferr(input logic st1, input bit two, input logic st2);
    return !st1 || (two && !st2);
  endfunction

  task automatic expect_word(input bit sel5, input string tag, input logic [8:0] d,
                             input logic pe, input logic fe);
    logic [10:0] w;
    int n = 0;
    while (((sel5 ? q5.size() : q8.size()) == 0) && n < 400) begin
      tick(1);
      n++;
    end
    if ((sel5 ? q5.size() : q8.size()) == 0) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      w = sel5 ? q5.pop_front() : q8.pop_front();
      $display("frame %s: data=0x%0h perr=%0b ferr=%0b (model 0x%0h %0b %0b)",
               tag, w[8:0], w[9], w[10], d, pe, fe);
      check({tag, " data"}, 32'(w[8:0]), 32'(d));
      check({tag, " parity_err"}, 32'(w[9]), 32'(pe));
      check({tag, " framing_err"}, 32'(w[10]), 32'(fe));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, a0, o0;
    logic [8:0] d;
    logic [1:0] pm;
    bit two, has_par;
    logic pbit, st1, st2;
    int cpd, ce, sp;

    resetn = 1'b0;
    line8 = 1'b1; line5 = 1'b1;
    cpd8 = 10'd16; pm8 = PAR_NONE; ts8 = 1'b0;
    cpd5 = 10'd3;  pm5 = PAR_ODD;  ts5 = 1'b0;
    if8.rx_ready = 1'b1; if5.rx_ready = 1'b1;
    tick(3);
    check("reset rx_valid", 32'(if8.rx_valid), 32'd0);
    check("reset rx_data", 32'(if8.rx_data), 32'd0);
    check("reset parity_err", 32'(if8.parity_err), 32'd0);
    check("reset framing_err", 32'(if8.framing_err), 32'd0);
    check("reset overrun_err", 32'(if8.overrun_err), 32'd0);
    check("reset busy", 32'(busy8), 32'd0);
    resetn = 1'b1;
    tick(3);

    // Plain 8N1 frame, consumer always ready.
    v0 = vcnt8;
    send_frame(0, 9'h0A5, 8, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    tick(4);
    expect_word(0, "a5", 9'h0A5, 1'b0, 1'b0);
    check("a5 valid cycles", 32'(vcnt8 - v0), 32'd1);

    // Even parity, wrong then correct parity bit.
    pm8 = PAR_EVEN;
    send_frame(0, 9'h007, 8, 16, 1, 1'b0, 1'b1, 0, 1'b1, -1);
    tick(4);
    expect_word(0, "even bad", 9'h007, model_perr(9'h007, 8, PAR_EVEN, 1'b0), 1'b0);
    send_frame(0, 9'h007, 8, 16, 1, 1'b1, 1'b1, 0, 1'b1, -1);
    tick(4);
    expect_word(0, "even good", 9'h007, model_perr(9'h007, 8, PAR_EVEN, 1'b1), 1'b0);

    // Two stop bits, second one low.
    pm8 = PAR_NONE; ts8 = 1'b1;
    send_frame(0, 9'h05A, 8, 16, 0, 1'b0, 1'b1, 1, 1'b0, -1);
    tick(4);
    expect_word(0, "stop2 low", 9'h05A, 1'b0, model_ferr(1'b1, 1, 1'b0));

    // Break: line low for a whole frame plus 3 more bit times.
    a0 = acc8;
    line8 = 1'b0;
    tick(16 * 14);
    check("break frame count", 32'(acc8 - a0), 32'd1);
    check("break busy held", 32'(busy8), 32'd1);
    line8 = 1'b1;
    tick(6);
    check("break busy released", 32'(busy8), 32'd0);
    check("break no extra frame", 32'(acc8 - a0), 32'd1);
    expect_word(0, "break", 9'h000, 1'b0, 1'b1);

    // Short glitch on an idle line must be rejected.
    ts8 = 1'b0;
    a0 = acc8;
    line8 = 1'b0;
    tick(2);
    line8 = 1'b1;
    tick(20);
    check("glitch busy", 32'(busy8), 32'd0);
    check("glitch no frame", 32'(acc8 - a0), 32'd0);

    // Single-clock spikes inside data bits are outvoted.
    send_frame(0, 9'h03C, 8, 16, 0, 1'b0, 1'b1, 0, 1'b1, 2);
    tick(4);
    expect_word(0, "spike b2", 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 16, 0, 1'b0, 1'b1, 0, 1'b1, 0);
    tick(4);
    expect_word(0, "spike b0", 9'h03C, 1'b0, 1'b0);

    // Overrun: consumer stalled across two frames.
    if8.rx_ready = 1'b0;
    o0 = ovr8;
    send_frame(0, 9'h011, 8, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    tick(3);
    send_frame(0, 9'h022, 8, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    tick(10);
    check("overrun valid held", 32'(if8.rx_valid), 32'd1);
    check("overrun data held", 32'(if8.rx_data), 32'h11);
    check("overrun pulses", 32'(ovr8 - o0), 32'd1);
    if8.rx_ready = 1'b1;
    tick(2);
    check("overrun valid drops", 32'(if8.rx_valid), 32'd0);
    expect_word(0, "overrun held", 9'h011, 1'b0, 1'b0);

    // Randomised frames against the model.
    o0 = ovr8;
    for (int k = 0; k < 24; k++) begin
      d       = 9'($urandom_range(0, 255));
      pm      = 2'($urandom_range(0, 3));
      two     = 1'($urandom_range(0, 1));
      cpd     = $urandom_range(3, 20);
      ce      = (cpd < MIN_CPD) ? MIN_CPD : cpd;
      has_par = (pm == PAR_EVEN) || (pm == PAR_ODD);
      pbit    = 1'($urandom_range(0, 1));
      st1     = ($urandom_range(0, 4) != 0);
      st2     = ($urandom_range(0, 4) != 0);
      sp      = $urandom_range(0, 11);
      cpd8 = 10'(cpd); pm8 = pm; ts8 = two;
      send_frame(0, d, 8, ce, has_par, pbit, st1, two, st2, sp);
      tick(2 + $urandom_range(0, ce));
      expect_word(0, $sformatf("rand%0d", k), d, model_perr(d, 8, pm, pbit),
                  model_ferr(st1, two, st2));
    end
    check("rand no overrun", 32'(ovr8 - o0), 32'd0);

    // 5-bit instance: clamped cpd, odd parity.
    send_frame(1, 9'h01F, 5, 8, 1, 1'b0, 1'b1, 0, 1'b1, -1);
    tick(4);
    expect_word(1, "d5 1f", 9'h01F, model_perr(9'h01F, 5, PAR_ODD, 1'b0), 1'b0);

    // Leave an undelivered word, start another frame, reset in the middle.
    if5.rx_ready = 1'b0;
    send_frame(1, 9'h00A, 5, 8, 1, 1'b1, 1'b1, 0, 1'b1, -1);
    tick(4);
    check("d5 held before reset", 32'(if5.rx_valid), 32'd1);
    line5 = 1'b0;
    tick(8 * 3);
    check("d5 busy mid-frame", 32'(busy5), 32'd1);
    resetn = 1'b0;
    tick(2);
    check("d5 reset rx_valid", 32'(if5.rx_valid), 32'd0);
    check("d5 reset rx_data", 32'(if5.rx_data), 32'd0);
    check("d5 reset parity_err", 32'(if5.parity_err), 32'd0);
    check("d5 reset framing_err", 32'(if5.framing_err), 32'd0);
    check("d5 reset overrun_err", 32'(if5.overrun_err), 32'd0);
    check("d5 reset busy", 32'(busy5), 32'd0);
    check("d5 no overrun", 32'(ovr5), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
